chip_loader: RTL and testbench
==============================

# chip_loader

Host-side transmitter for the convolution chip's load interface. On `start`, it streams kernel, input-tile and overlap-cache words from a source memory into the chip, one word per cycle. It drives the `a_input`/`b_input` address/data pair and the `int_mem_we`/`overlap_cache_we`/`b_zero` strobes, then pulses `data_ready` and waits for `fsm_done`. It sits in the testbench/host wrapper, on the opposite end of the chip's write port.

## Interface
- `IO_DATA_WIDTH`, 16: data word width; also the `a_input` width.
- `SRC_ADDR_WIDTH`, 20: source memory address width.
- `KERNEL_WORDS`, 512: kernel memory depth (max kernel length).
- `INPUT_WORDS`, 16384: input memory depth (max input length).
- `OVERLAP_WORDS`, 256: overlap cache depth (max overlap length).
- `clk` in 1: clock. One clock only.
- `arst_in` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle request, sampled only in IDLE.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `kernel_base`, `input_base`, `overlap_base` in SRC_ADDR_WIDTH each: source start addresses, sampled at start.
- `kernel_len`, `input_len`, `overlap_len` in $clog2(depth)+1 each: word counts, sampled at start.
- `src_read_en` out 1: source read strobe, registered.
- `src_read_addr` out SRC_ADDR_WIDTH: source address, registered.
- `src_qout` in IO_DATA_WIDTH: source data, valid exactly 1 cycle after `src_read_en`.
- `a_input` out IO_DATA_WIDTH: chip write address, registered.
- `b_input` out IO_DATA_WIDTH: chip write data, registered.
- `int_mem_we` out 1: kernel/input memory write strobe.
- `overlap_cache_we` out 1: overlap cache write strobe.
- `b_zero` out 1: chip forces input-memory data to 0.
- `data_ready` out 1: one-cycle pulse after the last write.
- `fsm_done` in 1: chip computation finished.

## Operation
- States: IDLE → [CLEAR] → KERNEL → INPUT → OVERLAP → READY → WAIT_DONE → DONE → IDLE.
- On start in IDLE, capture bases and lengths. A length greater than its depth is clamped to the depth.
- A phase with length 0 is skipped and takes zero cycles.
- Phase word idx runs 0..len-1. The source address is base+idx, wrapping modulo 2^SRC_ADDR_WIDTH.
- KERNEL: `a_input` = 0x8000 | idx[8:0]; `int_mem_we`=1.
- INPUT: `a_input` = idx[13:0], bit 15 = 0; `int_mem_we`=1.
- OVERLAP: `a_input` = idx[7:0], upper bits 0; `overlap_cache_we`=1; `int_mem_we`=0.
- Reads issue back-to-back across phase boundaries with no bubbles. Each write-stage entry carries a phase tag, so strobes follow the word, not the current state.
- READY: drive `data_ready` for exactly one cycle. `data_ready` never overlaps a write strobe.
- WAIT_DONE: sample `fsm_done`. Any `fsm_done` outside WAIT_DONE is ignored.
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE.
- `start` in any state other than IDLE is ignored. A start in the DONE cycle is also ignored.
- At most one write strobe is high per cycle. When no strobe is high, `a_input` and `b_input` hold their last values.
- Reset values: every output 0, state IDLE. Reset mid-transfer aborts immediately: strobes drop asynchronously, and no `data_ready` or `done` is issued.

## Timing
- `start` is sampled at cycle 0.
- `busy` is high from cycle 1 through the cycle before `done`.
- First `src_read_en` is at cycle 1, with addr = first non-empty base.
- A read issued at cycle T produces a write strobe with `b_input`=`src_qout` at cycle T+2.
- With N = kernel_len+input_len+overlap_len words:
  - writes occupy cycles 3..N+2;
  - `data_ready` is at cycle N+3;
  - if N=0, `data_ready` is at cycle 1.
- `fsm_done` sampled high at cycle D in WAIT_DONE → `done` at D+1, IDLE at D+2.
- `fsm_done` high during the `data_ready` cycle is not sampled.

## Configuration
- `CHIP_LOADER_CLEAR_EN` defined:
  - CLEAR phase runs before KERNEL on every start, even when all lengths are 0.
  - It writes INPUT_WORDS words: `a_input`=idx, `int_mem_we`=1, `b_zero`=1, `b_input`=0, no source reads.
  - Clear writes occupy cycles 1..INPUT_WORDS.
  - All later timing shifts by INPUT_WORDS cycles: first read at INPUT_WORDS+1, `data_ready` at N+INPUT_WORDS+3 (INPUT_WORDS+1 if N=0).
- Not defined: no CLEAR state, and `b_zero` is tied 0.

## Test plan
- Stream all phases:
  - kernel_len=2, input_len=3, overlap_len=1, src[k]=0x100+k, bases 0/16/32, start at 0.
  - Expected writes, one per cycle:
    - cycles 3-4: a=0x8000/0x8001, b=0x100/0x101, `int_mem_we`;
    - cycles 5-7: a=0/1/2, b=0x110..0x112;
    - cycle 8: a=0, b=0x120, `overlap_cache_we`.
  - `data_ready` at cycle 9.
- All lengths 0 → `data_ready` at cycle 1, no write strobes; `fsm_done` at 5 → `done` at 6.
- input_base=2^20-1, input_len=2 → source addresses 0xFFFFF then 0x00000; input_len=20000 → exactly 16384 input writes.
- Reset at the 4th input write → all outputs 0 in the same cycle; no `data_ready`; a later start behaves as from fresh.
- `start` repeated while busy and `fsm_done` pulsed before `data_ready` → both ignored; `done` follows only a WAIT_DONE `fsm_done`.
- With `CHIP_LOADER_CLEAR_EN`, kernel_len=1 → 16384 writes with `b_zero`=1 at cycles 1..16384; kernel write at cycle 16387; `data_ready` at 16388.

Source files
------------

// File: rtl/chip_loader.sv
// chip_loader: host-side streamer that copies kernel, input-tile and overlap-cache
// words from a source memory into the convolution chip's write port, then
// signals data_ready and waits for the chip's fsm_done.
//
// Ports:
//   clk, arst_in                   clock, asynchronous active-high reset
//   start / busy / done            request, in-progress flag, completion pulse
//   *_base, *_len                  per-phase source start address and word count
//   src_read_en / src_read_addr    registered source read request
//   src_qout                       source data, valid one cycle after the read
//   a_input / b_input              chip write address / data
//   int_mem_we, overlap_cache_we   chip write strobes
//   b_zero                         chip forces input-memory write data to 0
//   data_ready / fsm_done          handshake with the chip's compute FSM
//
// Optional feature: define CHIP_LOADER_CLEAR_EN to zero the whole input memory
// (CLEAR phase) before every transfer.
module chip_loader #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int SRC_ADDR_WIDTH = 20,
    parameter int KERNEL_WORDS = 512,
    parameter int INPUT_WORDS = 16384,
    parameter int OVERLAP_WORDS = 256,
    localparam int KLW = $clog2(KERNEL_WORDS) + 1,
    localparam int ILW = $clog2(INPUT_WORDS) + 1,
    localparam int OLW = $clog2(OVERLAP_WORDS) + 1
) (
    input  logic                      clk,
    input  logic                      arst_in,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic [SRC_ADDR_WIDTH-1:0] kernel_base,
    input  logic [SRC_ADDR_WIDTH-1:0] input_base,
    input  logic [SRC_ADDR_WIDTH-1:0] overlap_base,
    input  logic [KLW-1:0]            kernel_len,
    input  logic [ILW-1:0]            input_len,
    input  logic [OLW-1:0]            overlap_len,
    output logic                      src_read_en,
    output logic [SRC_ADDR_WIDTH-1:0] src_read_addr,
    input  logic [IO_DATA_WIDTH-1:0]  src_qout,
    output logic [IO_DATA_WIDTH-1:0]  a_input,
    output logic [IO_DATA_WIDTH-1:0]  b_input,
    output logic                      int_mem_we,
    output logic                      overlap_cache_we,
    output logic                      b_zero,
    output logic                      data_ready,
    input  logic                      fsm_done
);
    localparam int LW = (KLW > ILW) ? ((KLW > OLW) ? KLW : OLW) : ((ILW > OLW) ? ILW : OLW);
    localparam int KAW = $clog2(KERNEL_WORDS);
    localparam int IAW = $clog2(INPUT_WORDS);
    localparam int OAW = $clog2(OVERLAP_WORDS);
    typedef enum logic [2:0] {
        IDLE,
`ifdef CHIP_LOADER_CLEAR_EN
        CLEAR,
`endif
        KERNEL, INPUT, OVERLAP, READY, WAIT_DONE, DONE
    } state_t;
    state_t state_q, state_d, after_i, after_k, first_ph;
    logic [LW-1:0] idx_q, idx_d, kl_q, il_q, ol_q, kl_c, il_c, ol_c, cur_len;
    logic [SRC_ADDR_WIDTH-1:0] kb_q, ib_q, ob_q, kb_c, ib_c, ob_c, base_d;
    logic [SRC_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic rd_en_q, rd_en_d;
    // p1: read in flight, tagged with its chip address and target memory
    logic p1_v_q, p1_ov_q;
    logic [IO_DATA_WIDTH-1:0] p1_a_q, p1_a_d;
    logic wi_q, wi_d, wo_q, wo_d, bz_q, bz_d;
    logic [IO_DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic last, drained;
    // In IDLE the start-time inputs are used directly so the first read can be
    // issued on the same edge that captures them.
    assign kl_c = (state_q == IDLE) ? ((kernel_len > KLW'(KERNEL_WORDS)) ? LW'(KERNEL_WORDS) : LW'(kernel_len)) : kl_q;
    assign il_c = (state_q == IDLE) ? ((input_len > ILW'(INPUT_WORDS)) ? LW'(INPUT_WORDS) : LW'(input_len)) : il_q;
    assign ol_c = (state_q == IDLE) ? ((overlap_len > OLW'(OVERLAP_WORDS)) ? LW'(OVERLAP_WORDS) : LW'(overlap_len)) : ol_q;
    assign kb_c = (state_q == IDLE) ? kernel_base : kb_q;
    assign ib_c = (state_q == IDLE) ? input_base : ib_q;
    assign ob_c = (state_q == IDLE) ? overlap_base : ob_q;
    // Empty phases are skipped by jumping straight to the next non-empty one.
    assign after_i = (ol_c != '0) ? OVERLAP : READY;
    assign after_k = (il_c != '0) ? INPUT : after_i;
    assign first_ph = (kl_c != '0) ? KERNEL : after_k;
    assign cur_len = (state_q == KERNEL) ? kl_q : (state_q == INPUT) ? il_q : ol_q;
    assign last = (idx_q + LW'(1)) == cur_len;
    assign drained = !p1_v_q && !wi_q && !wo_q;
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef CHIP_LOADER_CLEAR_EN
                    state_d = CLEAR;
`else
                    state_d = first_ph;
`endif
                    idx_d = '0;
                end
            end
`ifdef CHIP_LOADER_CLEAR_EN
            CLEAR: begin
                idx_d = (idx_q == LW'(INPUT_WORDS - 1)) ? '0 : idx_q + LW'(1);
                state_d = (idx_q == LW'(INPUT_WORDS - 1)) ? first_ph : CLEAR;
            end
`endif
            KERNEL: begin
                idx_d = last ? '0 : idx_q + LW'(1);
                state_d = last ? after_k : KERNEL;
            end
            INPUT: begin
                idx_d = last ? '0 : idx_q + LW'(1);
                state_d = last ? after_i : INPUT;
            end
            OVERLAP: begin
                idx_d = last ? '0 : idx_q + LW'(1);
                state_d = last ? READY : OVERLAP;
            end
            READY: state_d = drained ? WAIT_DONE : READY;
            WAIT_DONE: state_d = fsm_done ? DONE : WAIT_DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // The read register always describes the word of the state being entered.
    always_comb begin
        rd_en_d = state_d inside {KERNEL, INPUT, OVERLAP};
        base_d = (state_d == KERNEL) ? kb_c : (state_d == INPUT) ? ib_c : ob_c;
        rd_addr_d = rd_en_d ? base_d + SRC_ADDR_WIDTH'(idx_d) : rd_addr_q;
        p1_a_d = (state_q == KERNEL) ? ({1'b1, {(IO_DATA_WIDTH-1){1'b0}}} | IO_DATA_WIDTH'(idx_q[KAW-1:0]))
               : (state_q == INPUT) ? IO_DATA_WIDTH'(idx_q[IAW-1:0]) : IO_DATA_WIDTH'(idx_q[OAW-1:0]);
    end
    // Strobes follow the tag carried with each word, not the current state.
    always_comb begin
        wi_d = p1_v_q && !p1_ov_q;
        wo_d = p1_v_q && p1_ov_q;
        bz_d = 1'b0;
        a_d = p1_v_q ? p1_a_q : a_q;
        b_d = p1_v_q ? src_qout : b_q;
`ifdef CHIP_LOADER_CLEAR_EN
        if ((state_q == IDLE && start) || (state_q == CLEAR && state_d == CLEAR)) begin
            wi_d = 1'b1;
            bz_d = 1'b1;
            a_d = IO_DATA_WIDTH'(idx_d);
            b_d = '0;
        end
`endif
    end
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_q <= IDLE;
            idx_q <= '0;
            kl_q <= '0;
            il_q <= '0;
            ol_q <= '0;
            kb_q <= '0;
            ib_q <= '0;
            ob_q <= '0;
            rd_en_q <= 1'b0;
            rd_addr_q <= '0;
            p1_v_q <= 1'b0;
            p1_ov_q <= 1'b0;
            p1_a_q <= '0;
            wi_q <= 1'b0;
            wo_q <= 1'b0;
            bz_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            if (state_q == IDLE && start) begin
                kl_q <= kl_c;
                il_q <= il_c;
                ol_q <= ol_c;
                kb_q <= kb_c;
                ib_q <= ib_c;
                ob_q <= ob_c;
            end
            rd_en_q <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            p1_v_q <= rd_en_q;
            p1_ov_q <= state_q == OVERLAP;
            p1_a_q <= p1_a_d;
            wi_q <= wi_d;
            wo_q <= wo_d;
            bz_q <= bz_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end
    assign busy = state_q != IDLE && state_q != DONE;
    assign done = state_q == DONE;
    assign data_ready = state_q == READY && drained;
    assign src_read_en = rd_en_q;
    assign src_read_addr = rd_addr_q;
    assign a_input = a_q;
    assign b_input = b_q;
    assign int_mem_we = wi_q;
    assign overlap_cache_we = wo_q;
    assign b_zero = bz_q;
endmodule

// File: tb/tb_chip_loader.sv
// tb_chip_loader: table-driven scoreboard bench for chip_loader
module tb_chip_loader;
`ifdef CHIP_LOADER_CLEAR_EN
    localparam int OFS = 16384;
`else
    localparam int OFS = 0;
`endif
    typedef struct {
        logic [19:0] kb, ib, ob;
        logic [9:0]  kl;
        logic [14:0] il;
        logic [8:0]  ol;
        bit          noise;
        int          dr;
    } vec_t;
    typedef struct {
        logic [15:0] a, b;
        logic        ov, bz;
        int          cy;
    } wr_t;

    logic clk = 1'b0, arst_in = 1'b1, start = 1'b0, fsm_done = 1'b0;
    logic busy, done, src_read_en, int_mem_we, overlap_cache_we, b_zero, data_ready;
    logic [19:0] kernel_base = '0, input_base = '0, overlap_base = '0, src_read_addr;
    logic [9:0]  kernel_len = '0;
    logic [14:0] input_len = '0;
    logic [8:0]  overlap_len = '0;
    logic [15:0] src_qout = '0, a_input, b_input, last_a = '0, last_b = '0;
    int total = 0, bad = 0, cyc = 0, t0 = 0;
    wr_t exp_q[$];
    vec_t tab[9];

    chip_loader dut (
        .clk(clk), .arst_in(arst_in), .start(start), .busy(busy), .done(done),
        .kernel_base(kernel_base), .input_base(input_base), .overlap_base(overlap_base),
        .kernel_len(kernel_len), .input_len(input_len), .overlap_len(overlap_len),
        .src_read_en(src_read_en), .src_read_addr(src_read_addr), .src_qout(src_qout),
        .a_input(a_input), .b_input(b_input), .int_mem_we(int_mem_we),
        .overlap_cache_we(overlap_cache_we), .b_zero(b_zero), .data_ready(data_ready),
        .fsm_done(fsm_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] srcf(input logic [19:0] a);
        return (a[15:0] + 16'h0100) ^ {a[19:16], 12'h000};
    endfunction

    always @(posedge clk) src_qout <= src_read_en ? srcf(src_read_addr) : 16'hDEAD;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (arst_in) begin
            last_a = '0;
            last_b = '0;
        end else begin
            if (int_mem_we || overlap_cache_we) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL write_extra: got a=%h b=%h at cycle %0d, none expected", a_input, b_input, cyc - t0);
                end else begin
                    e = exp_q.pop_front();
                    if (a_input !== e.a || b_input !== e.b || overlap_cache_we !== e.ov || int_mem_we !== !e.ov
                        || b_zero !== e.bz || cyc - t0 != e.cy) begin
                        bad++;
                        $display("FAIL write: got a=%h b=%h ov=%b int=%b bz=%b cyc=%0d want a=%h b=%h ov=%b bz=%b cyc=%0d",
                                 a_input, b_input, overlap_cache_we, int_mem_we, b_zero, cyc - t0, e.a, e.b, e.ov, e.bz, e.cy);
                    end
                end
                last_a = a_input;
                last_b = b_input;
            end else if (a_input !== last_a || b_input !== last_b) begin
                total++;
                bad++;
                $display("FAIL hold: got a=%h b=%h want a=%h b=%h", a_input, b_input, last_a, last_b);
            end
            if (int_mem_we && overlap_cache_we) begin
                total++;
                bad++;
                $display("FAIL two_strobes: got both high want at most one");
            end
            if (data_ready && (int_mem_we || overlap_cache_we)) begin
                total++;
                bad++;
                $display("FAIL dr_overlap: got data_ready with strobe want none");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input vec_t v);
        int kl, il, ol, n;
        kl = (v.kl > 512) ? 512 : int'(v.kl);
        il = (v.il > 16384) ? 16384 : int'(v.il);
        ol = (v.ol > 256) ? 256 : int'(v.ol);
        n = 0;
`ifdef CHIP_LOADER_CLEAR_EN
        for (int i = 0; i < 16384; i++) exp_q.push_back('{a: 16'(i), b: 16'h0, ov: 1'b0, bz: 1'b1, cy: 1 + i});
`endif
        for (int i = 0; i < kl; i++) begin
            exp_q.push_back('{a: 16'h8000 | 16'(i), b: srcf(v.kb + 20'(i)), ov: 1'b0, bz: 1'b0, cy: OFS + 3 + n});
            n++;
        end
        for (int i = 0; i < il; i++) begin
            exp_q.push_back('{a: 16'(i), b: srcf(v.ib + 20'(i)), ov: 1'b0, bz: 1'b0, cy: OFS + 3 + n});
            n++;
        end
        for (int i = 0; i < ol; i++) begin
            exp_q.push_back('{a: 16'(i), b: srcf(v.ob + 20'(i)), ov: 1'b1, bz: 1'b0, cy: OFS + 3 + n});
            n++;
        end
    endtask

    task automatic launch(input vec_t v);
        kernel_base = v.kb;
        input_base = v.ib;
        overlap_base = v.ob;
        kernel_len = v.kl;
        input_len = v.il;
        overlap_len = v.ol;
        start = 1'b1;
        t0 = cyc;
        push_exp(v);
    endtask

    task automatic run_vec(input vec_t v);
        int c, n;
        bit got;
        logic [19:0] fb;
        n = ((v.kl > 512) ? 512 : int'(v.kl)) + ((v.il > 16384) ? 16384 : int'(v.il)) + ((v.ol > 256) ? 256 : int'(v.ol));
        fb = (v.kl != 0) ? v.kb : (v.il != 0) ? v.ib : v.ob;
        launch(v);
        step();
        c = 1;
        start = v.noise;
        fsm_done = v.noise;
        chk("busy_c1", busy, 1);
        chk("rd_en_c1", src_read_en, (OFS == 0 && n > 0));
        if (OFS == 0 && n > 0) chk("rd_addr_c1", src_read_addr, fb);
        got = 0;
        while (c <= v.dr + OFS + 20) begin
            if (data_ready) begin
                got = 1;
                break;
            end
            step();
            c++;
        end
        chk("dr_cycle", got ? c : -1, v.dr + OFS);
        if (!got) begin
            start = 0;
            fsm_done = 0;
            return;
        end
        chk("writes_left", exp_q.size(), 0);
        step();
        chk("no_done_after_dr", done, 0);
        start = 0;
        fsm_done = 0;
        step();
        step();
        step();
        chk("wait_busy", {busy, done}, 2'b10);
        fsm_done = 1;
        step();
        chk("done_pulse", {busy, done}, 2'b01);
        fsm_done = 0;
        start = v.noise;
        step();
        chk("idle_after_done", {busy, done}, 2'b00);
        start = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test want finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tab[0] = '{kb: 20'h0, ib: 20'h10, ob: 20'h20, kl: 10'd2, il: 15'd3, ol: 9'd1, noise: 0, dr: 9};
        tab[1] = '{kb: 20'h0, ib: 20'h0, ob: 20'h0, kl: 10'd0, il: 15'd0, ol: 9'd0, noise: 0, dr: 1};
        tab[2] = '{kb: 20'h0, ib: 20'hFFFFF, ob: 20'h0, kl: 10'd0, il: 15'd2, ol: 9'd0, noise: 0, dr: 5};
        tab[3] = '{kb: 20'hFFFFE, ib: 20'h0, ob: 20'h12345, kl: 10'd3, il: 15'd0, ol: 9'd4, noise: 0, dr: 10};
        tab[4] = '{kb: 20'h0, ib: 20'h00400, ob: 20'h0, kl: 10'd0, il: 15'd20000, ol: 9'd0, noise: 0, dr: 16387};
        tab[5] = '{kb: 20'h5, ib: 20'h64, ob: 20'hC8, kl: 10'd1, il: 15'd1, ol: 9'd1, noise: 1, dr: 6};
        tab[6] = '{kb: 20'h0, ib: 20'h0, ob: 20'h0, kl: 10'd0, il: 15'd0, ol: 9'd0, noise: 1, dr: 1};
        tab[7] = '{kb: 20'h7, ib: 20'h0, ob: 20'hFFFF0, kl: 10'd600, il: 15'd0, ol: 9'd300, noise: 0, dr: 771};
        tab[8] = '{kb: 20'h30, ib: 20'h0, ob: 20'h0, kl: 10'd1, il: 15'd0, ol: 9'd0, noise: 0, dr: 4};
        step();
        step();
        chk("rst_ctrl", {busy, done, src_read_en, int_mem_we, overlap_cache_we, b_zero, data_ready}, 0);
        chk("rst_data", {src_read_addr, a_input, b_input}, 0);
        arst_in = 0;
        step();
        for (int i = 0; i < 9; i++) begin
`ifdef CHIP_LOADER_CLEAR_EN
            if (i != 1 && i != 8) continue;
`endif
            run_vec(tab[i]);
        end
        launch('{kb: 20'h0, ib: 20'h40, ob: 20'h0, kl: 10'd2, il: 15'd6, ol: 9'd0, noise: 0, dr: 11});
        step();
        start = 0;
        for (int k = 1; k < 8 + OFS; k++) step();
        chk("rst_pre_we", {int_mem_we, a_input}, {1'b1, 16'h0003});
        #1 arst_in = 1;
        #1;
        chk("rst_mid_ctrl", {busy, done, src_read_en, int_mem_we, overlap_cache_we, b_zero, data_ready}, 0);
        chk("rst_mid_data", {src_read_addr, a_input, b_input}, 0);
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_quiet", {data_ready, done, busy}, 0);
        end
        arst_in = 0;
        step();
        run_vec(tab[0]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
